// File: rtl/uart_cmd_parser.sv
// Byte-stream command frame parser: HEADER, OPCODE, LEN, payload, CSUM.
// Decoded commands are held on a valid/ready output; framing errors raise a one-cycle strobe.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_data_valid,
    output logic                   rx_data_ready,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             cmd_opcode,
    output logic [4:0]             cmd_len,
    output logic [8*MAX_LEN-1:0]   cmd_payload,
    output logic                   err_pulse,
    output logic [1:0]             err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OPC  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_PAY  = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

    logic [2:0]  state;
    logic [7:0]  acc;
    logic [4:0]  idx;
    logic [31:0] cnt;
    logic        accept;
    logic        in_frame;
    logic        timeout;

    assign rx_data_ready = (state != S_OUT);
    assign cmd_valid     = (state == S_OUT);
    assign accept        = rx_data_valid && rx_data_ready;
    assign in_frame      = (state == S_OPC) || (state == S_LEN) ||
                           (state == S_PAY) || (state == S_CSUM);
    // An accepted byte in the final cycle wins over the timeout.
    assign timeout       = in_frame && (cnt == TO_LAST) && !accept;

    // Every entry into a frame state coincides with an accepted byte, so clearing
    // on accept also covers clearing on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!in_frame || accept || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            idx         <= '0;
            cmd_opcode  <= '0;
            cmd_len     <= '0;
            cmd_payload <= '0;
            err_pulse   <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && rx_data == HEADER) begin
                        state       <= S_OPC;
                        acc         <= '0;
                        cmd_payload <= '0;
                    end
                end
                S_OPC: begin
                    if (accept) begin
                        cmd_opcode <= rx_data;
                        acc        <= acc + rx_data;
                        state      <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (rx_data > MAX_LEN_B) begin
                            err_pulse <= 1'b1;
                            err_code  <= 2'b01;
                            state     <= S_IDLE;
                        end else begin
                            cmd_len <= rx_data[4:0];
                            acc     <= acc + rx_data;
                            idx     <= '0;
                            state   <= (rx_data == 8'd0) ? S_CSUM : S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx == 5'(i)) cmd_payload[8*i +: 8] <= rx_data;
                        end
                        acc <= acc + rx_data;
                        idx <= idx + 5'd1;
                        if (idx == cmd_len - 5'd1) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rx_data == acc) begin
                            state <= S_OUT;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= 2'b10;
                            state     <= S_IDLE;
                        end
                    end
                end
                S_OUT: begin
                    if (cmd_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (timeout) begin
                err_pulse <= 1'b1;
                err_code  <= 2'b11;
                state     <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames plus a randomized byte stream,
// checked against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int         MAX_LEN = 16;
    localparam int         T       = 20;
    localparam logic [7:0] HDR     = 8'hA5;

    typedef struct {
        logic [7:0]           opc;
        logic [4:0]           len;
        logic [8*MAX_LEN-1:0] pay;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           rx_data = '0;
    logic                 rx_data_valid = 1'b0;
    logic                 rx_data_ready;
    logic                 cmd_valid;
    logic                 cmd_ready = 1'b0;
    logic [7:0]           cmd_opcode;
    logic [4:0]           cmd_len;
    logic [8*MAX_LEN-1:0] cmd_payload;
    logic                 err_pulse;
    logic [1:0]           err_code;

    cmd_t       exp_cmd[$];
    logic [1:0] exp_err[$];
    logic [7:0] frame[$];
    bit         in_frame = 1'b0;
    int         extra_idle = 0;
    int         rdy_mode = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    uart_cmd_parser #(.HEADER(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .cmd_payload(cmd_payload),
        .err_pulse(err_pulse), .err_code(err_code)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input logic [127:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Reference model: collects whole frames and judges them by the frame rules.
    task automatic model_byte(input logic [7:0] b, input int gap);
        logic [7:0] sum;
        cmd_t       c;
        int         total;
        total      = gap + extra_idle;
        extra_idle = 0;
        if (in_frame && total >= T) begin
            exp_err.push_back(2'b11);
            in_frame = 1'b0;
        end
        if (!in_frame) begin
            if (b == HDR) begin
                in_frame = 1'b1;
                frame.delete();
            end
            return;
        end
        frame.push_back(b);
        if (frame.size() == 2 && frame[1] > MAX_LEN) begin
            exp_err.push_back(2'b01);
            in_frame = 1'b0;
            return;
        end
        if (frame.size() >= 2 && frame.size() == int'(frame[1]) + 3) begin
            sum = 8'd0;
            for (int i = 0; i < frame.size() - 1; i++) sum = sum + frame[i];
            if (sum == b) begin
                c.opc = frame[0];
                c.len = frame[1][4:0];
                c.pay = '0;
                for (int i = 0; i < int'(frame[1]); i++) c.pay[8*i +: 8] = frame[2+i];
                exp_cmd.push_back(c);
            end else begin
                exp_err.push_back(2'b10);
            end
            in_frame = 1'b0;
        end
    endtask

    // Called at posedge+1; `gap` idle edges precede the byte, which then waits for ready.
    task automatic send(input logic [7:0] b, input int gap);
        bit r;
        bit done;
        model_byte(b, gap);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        rx_data       = b;
        rx_data_valid = 1'b1;
        done          = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            r = rx_data_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        rx_data_valid = 1'b0;
        if (!done) fail_msg("byte_not_accepted", b);
    endtask

    task automatic idle(input int n);
        extra_idle += n;
        if (in_frame && extra_idle >= T) begin
            exp_err.push_back(2'b11);
            in_frame   = 1'b0;
            extra_idle = 0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_data_valid = 1'b0;
        rst_n         = 1'b0;
        in_frame      = 1'b0;
        extra_idle    = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rand_gap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 70) return $urandom_range(0, 2);
        if (r < 88) return $urandom_range(3, 8);
        if (r < 95) return T - 1;
        return $urandom_range(T, T + 4);
    endfunction

    // Downstream ready: random, forced low, or forced high.
    initial begin
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       cmd_ready = ($urandom_range(0, 2) == 0);
                1:       cmd_ready = 1'b0;
                default: cmd_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations whenever the DUT presents a command or an error.
    initial begin
        cmd_t cur;
        bit   have;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
            end else begin
                if (err_pulse) begin
                    if (exp_err.size() == 0) fail_msg("unexpected_err_pulse", err_code);
                    else check("err_code", err_code, exp_err.pop_front());
                end
                if (cmd_valid && !have) begin
                    if (exp_cmd.size() == 0) begin
                        fail_msg("unexpected_cmd_valid", cmd_opcode);
                        cur.opc = cmd_opcode;
                        cur.len = cmd_len;
                        cur.pay = cmd_payload;
                    end else begin
                        cur = exp_cmd.pop_front();
                    end
                    have = 1'b1;
                end
                if (cmd_valid) begin
                    check("cmd_opcode", cmd_opcode, cur.opc);
                    check("cmd_len", cmd_len, cur.len);
                    check("cmd_payload", cmd_payload, cur.pay);
                end else begin
                    have = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        logic [7:0] sum;
        logic [7:0] b;
        int         kind;
        int         len;
        bit         done;

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        check("rst_rx_ready", rx_data_ready, 1'b1);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_code", err_code, 2'b00);
        check("rst_opcode", cmd_opcode, 8'h00);
        check("rst_len", cmd_len, 5'd0);
        check("rst_payload", cmd_payload, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Good frame with 1-cycle valid latency
        rdy_mode = 1;
        send(HDR, 0); send(8'h10, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0); send(8'h45, 0);
        check("good_latency_valid", cmd_valid, 1'b1);
        check("good_payload_raw", cmd_payload, 128'h2211);
        rdy_mode = 2;
        idle(3);
        rdy_mode = 0;

        // Bad checksum, then a good frame
        send(HDR, 0); send(8'h10, 0); send(8'h02, 0); send(8'h11, 0); send(8'h22, 0); send(8'h46, 0);
        check("badcsum_no_valid", cmd_valid, 1'b0);
        send(HDR, 1); send(8'h33, 0); send(8'h01, 0); send(8'hA5, 0); send(8'hD9, 0);
        idle(6);

        // Bad length, trailing bytes discarded in idle
        send(HDR, 0); send(8'h10, 0); send(8'h11, 0);
        send(8'h00, 0); send(8'hFF, 0);
        idle(3);
        check("err_code_held", err_code, 2'b01);

        // Timeout after T idle cycles, and a byte at the last cycle that rescues the frame
        send(HDR, 0); send(8'h10, 0); send(8'h02, T);
        check("timeout_code", err_code, 2'b11);
        send(HDR, 0); send(8'h10, 0); send(8'h02, T - 1); send(8'h11, 0); send(8'h22, 0); send(8'h45, 0);
        idle(8);

        // Back-pressure on a zero-length frame
        rdy_mode = 1;
        idle(1);
        send(HDR, 0); send(8'h07, 0); send(8'h00, 0); send(8'h07, 0);
        check("bp_valid_rise", cmd_valid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            check("bp_valid_hold", cmd_valid, 1'b1);
            check("bp_rx_ready_low", rx_data_ready, 1'b0);
        end
        rdy_mode = 2;
        done = 1'b0;
        for (int k = 0; k < 6 && !done; k++) begin
            @(posedge clk);
            if (cmd_ready) begin
                done = 1'b1;
                #1;
                check("bp_valid_drop", cmd_valid, 1'b0);
                check("bp_rx_ready_back", rx_data_ready, 1'b1);
            end
        end
        if (!done) fail_msg("bp_handshake_missing", cmd_valid);
        @(posedge clk);
        #1;
        rdy_mode = 0;

        // Reset mid-frame discards it
        send(HDR, 0); send(8'h10, 0);
        do_reset();
        send(8'h02, 0); send(8'h11, 0);
        idle(T + 5);
        check("reset_no_valid", cmd_valid, 1'b0);

        // Randomized stream
        for (int f = 0; f < 150; f++) begin
            bq.delete();
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                    b = 8'($urandom);
                    if (b == HDR) b = 8'h00;
                    bq.push_back(b);
                end
            end else if (kind == 1) begin
                bq.push_back(HDR);
                bq.push_back(8'($urandom));
                bq.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = $urandom_range(0, MAX_LEN);
                bq.push_back(HDR);
                bq.push_back(8'($urandom));
                bq.push_back(8'(len));
                for (int i = 0; i < len; i++) begin
                    b = ($urandom_range(0, 7) == 0) ? HDR : 8'($urandom);
                    bq.push_back(b);
                end
                sum = 8'd0;
                for (int i = 1; i < bq.size(); i++) sum = sum + bq[i];
                if (kind == 2) sum = sum ^ 8'($urandom_range(1, 255));
                bq.push_back(sum);
            end
            foreach (bq[i]) send(bq[i], rand_gap());
        end

        // Drain: let any open frame time out and outstanding commands complete
        idle(T + 5);
        rdy_mode = 2;
        for (int k = 0; k < 200 && (exp_cmd.size() != 0 || cmd_valid); k++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("cmd_queue_drained", exp_cmd.size(), 0);
        check("err_queue_drained", exp_err.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
